mul_shift_add: RTL
==================

# mul_shift_add

Parametrised sequential shift-and-add multiplier with a start/done handshake. It replaces the repeated-addition multiplier, whose latency grows with the operand value, with one that retires one multiplier bit per cycle. Latency is bounded by WIDTH+1 cycles and exits early once no set multiplier bits remain. It adds signed/unsigned operation and separate operand buses, and sits as a shared arithmetic unit behind any controller that issues one multiply at a time.

## Interface
- WIDTH, 16, operand width in bits (≥2); product is 2*WIDTH bits
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; captured with start
- a_in  in  WIDTH  multiplicand; captured with start
- b_in  in  WIDTH  multiplier; captured with start
- product  out  2*WIDTH  result register; holds until the next completion
- done  out  1  one-cycle pulse when product is updated
- busy  out  1  high whenever state ≠ IDLE

## Operation
- Reset (async, rst_n=0): state IDLE, product=0, done=0, busy=0, internal registers cleared. Effective immediately, including mid-CALC; the in-flight operation is discarded.
- IDLE: start=1 at an edge captures the operands and moves to CALC:
  - In signed mode, magnitudes are captured: |a| into a 2*WIDTH accumulator-shift register, |b| into a WIDTH shift register.
  - neg = signed_mode & (a_in[MSB] ^ b_in[MSB]); the accumulator is cleared.
  - |−2^(WIDTH−1)| = 2^(WIDTH−1) is held as an unsigned WIDTH-bit value without overflow.
- CALC, each cycle:
  - if B[0]: ACC += A
  - A <<= 1; B >>= 1
  - When the shifted B is zero, go to DONE and write product = neg ? −ACCnext : ACCnext (2*WIDTH-bit two's complement).
  - If |b| = 0, exactly one CALC cycle runs and product = 0. neg has no effect on zero.
- DONE: done=1 for this single cycle, then IDLE unconditionally. start is ignored in CALC and DONE; no queuing.
- Unsigned mode: operands are used raw and neg=0.
- No overflow is possible; the full 2*WIDTH product is always exact.

## Timing
- N = number of CALC cycles = max(1, index of highest set bit of |b| + 1); 1 ≤ N ≤ WIDTH.
- Start is accepted at edge 0. busy rises after edge 0, CALC spans edges 1..N, and product and done update after edge N. Start-to-done latency is N cycles; busy is high for N+1 cycles.
- The earliest next start is accepted at the edge that ends the DONE cycle (state IDLE again), giving a throughput of one multiply per N+1 cycles.
- product changes only at the CALC→DONE edge or on reset.
- a_in, b_in and signed_mode may change freely after the start edge.

## Structure
- Shared package mul_pkg:
  - state typedef/constants: IDLE=2'd0, CALC=2'd1, DONE=2'd2
  - a function for the WIDTH-bit magnitude
- One natural sub-module, mul_sa_control: FSM only.
  - Inputs: start, bz (next B is zero).
  - Outputs: ld (operand capture), step (shift/accumulate), wr_p (product write), done, busy.
- The datapath (A, B, ACC, neg, product registers, adder, negator) lives in mul_shift_add itself, keeping the existing datapath/control split.

## Test plan
- WIDTH=16, unsigned, a=17, b=5 → N=3; done pulses 3 cycles after start; product=85; busy high 4 cycles.
- Signed, a=−3 (0xFFFD), b=7 → N=3; product=0xFFFFFFEB (−21). Signed, a=−32768, b=−32768 → N=16; product=0x40000000.
- Unsigned, a=0xFFFF, b=0xFFFF → N=16; product=0xFFFE0001. Signed, a=−5, b=0 → N=1; product=0.
- start held high continuously, or pulsed during CALC/DONE → no restart. A new operation begins only from IDLE; product from the first operation is stable until the second completes.
- rst_n asserted asynchronously mid-CALC (between edges) → product=0, busy=0, done=0 immediately. After release, a new start (a=6, b=9, N=4) yields 54 with the correct latency.
- Randomised sweep: WIDTH=8 and 16, both modes, 1000 operands against a reference product. Check N equals the bit-length rule every time and that done is exactly one cycle wide.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared types and helpers for the shift-and-add multiplier.
package mul_pkg;

  localparam int unsigned MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Magnitude of a w-bit two's-complement value held in the low bits of x.
  // The most negative value maps to 2^(w-1), which still fits in w unsigned bits.
  function automatic logic [MAX_W-1:0] magnitude(input logic [MAX_W-1:0] x,
                                                 input int unsigned     w);
    logic [MAX_W-1:0] mask;
    logic [5:0]       msb;
    mask = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
    msb  = 6'(w - 1);
    if (x[msb]) magnitude = (~x + MAX_W'(1)) & mask;
    else        magnitude = x & mask;
  endfunction

endpackage

// File: rtl/mul_sa_control.sv
// Control FSM: sequences operand capture, one shift/accumulate per cycle and the product write.
module mul_sa_control
  import mul_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic bz,
  output logic ld,
  output logic step,
  output logic wr_p,
  output logic done,
  output logic busy
);

  state_t state_q, state_d;

  // State register; done/busy are registered from the next state so they align with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= (state_d == DONE);
      busy    <= (state_d != IDLE);
    end
  end

  // Next-state logic; start only matters in IDLE, DONE always returns to IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (bz)    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath strobes decoded from the current state.
  always_comb begin
    ld   = 1'b0;
    step = 1'b0;
    wr_p = 1'b0;
    unique case (state_q)
      IDLE:    ld = start;
      CALC: begin
        step = 1'b1;
        wr_p = bz;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mul_shift_add.sv
// Sequential shift-and-add multiplier, one multiplier bit per cycle with early exit.
module mul_shift_add
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic [2*WIDTH-1:0] product,
  output logic               done,
  output logic               busy
);

  localparam int unsigned PW = 2 * WIDTH;

  logic [PW-1:0]    a_q, acc_q, acc_nxt;
  logic [WIDTH-1:0] b_q, b_nxt;
  logic [WIDTH-1:0] a_op, b_op;
  logic             neg_q;
  logic             ld, step, wr_p, bz;

  // Operand selection: magnitudes in signed mode, raw bits otherwise.
  always_comb begin
    a_op = a_in;
    b_op = b_in;
    if (signed_mode) begin
      a_op = WIDTH'(magnitude(MAX_W'(a_in), WIDTH));
      b_op = WIDTH'(magnitude(MAX_W'(b_in), WIDTH));
    end
  end

  // One iteration: conditional add of the shifted multiplicand, then retire one multiplier bit.
  always_comb begin
    acc_nxt = b_q[0] ? (acc_q + a_q) : acc_q;
    b_nxt   = b_q >> 1;
    bz      = (b_nxt == '0);
  end

  // Working registers: capture on ld, shift/accumulate on step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      neg_q <= 1'b0;
    end else if (ld) begin
      a_q   <= PW'(a_op);
      b_q   <= b_op;
      acc_q <= '0;
      neg_q <= signed_mode & (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
    end else if (step) begin
      a_q   <= a_q << 1;
      b_q   <= b_nxt;
      acc_q <= acc_nxt;
    end
  end

  // Result register, written only on the final iteration; negating zero stays zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) product <= '0;
    else if (wr_p) product <= neg_q ? (~acc_nxt + PW'(1)) : acc_nxt;
  end

  mul_sa_control u_ctrl (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bz    (bz),
    .ld    (ld),
    .step  (step),
    .wr_p  (wr_p),
    .done  (done),
    .busy  (busy)
  );

endmodule
